cpu_ctrl_fsm: RTL and testbench

Multi-cycle control state machine that sequences the 10-bit-instruction CPU datapath, replacing the free-running 16-phase counter. It fetches an instruction from the memory part, then generates read, execute, write and PC-update strobes for the calculation part. Each instruction takes a fixed, parameterised number of cycles. Instruction 0 is a sticky HALT, and a Run input gates issue.

---
 rtl/cpu_ctrl_fsm_if.sv | 61 ++++++
 rtl/cpu_ctrl_fsm.sv | 209 ++++++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_fsm_if
// Bundles the signals between the CPU control FSM and the datapath.
//   master (control FSM) : drives all strobes, addresses, opcode and debug state
//   slave  (datapath/tb) : drives run, ir, q (and step when SINGLE_STEP_EN)
// Signals:
//   run        issue enable          ir         instruction register
//   q          zero/condition flag   step       single-step request (optional)
//   ir_load    IR load pulse         pc_load    PC update pulse
//   jmux       1 = PC+1, 0 = branch  rae/rbe    read-port enables
//   raa/rba    read-port addresses   ie         immediate/DataIn select
//   ze/oe/we   flag/output/write strobes
//   wa         write address         op         ALU opcode
//   cal_value  immediate operand     halted     high in HALT
//   state      encoded FSM state
// Optional feature macro: SINGLE_STEP_EN (adds step).
// ---------------------------------------------------------------------------
interface cpu_ctrl_fsm_if #(
  parameter int INSTRUCTION_LEN = 10
);
  logic                       run;
  logic [INSTRUCTION_LEN-1:0] ir;
  logic                       q;
`ifdef SINGLE_STEP_EN
  logic                       step;
`endif
  logic                       ir_load;
  logic                       pc_load;
  logic                       jmux;
  logic                       rae;
  logic                       rbe;
  logic [1:0]                 raa;
  logic [1:0]                 rba;
  logic                       ie;
  logic                       ze;
  logic                       oe;
  logic                       we;
  logic [1:0]                 wa;
  logic [2:0]                 op;
  logic [3:0]                 cal_value;
  logic                       halted;
  logic [2:0]                 state;

  modport master (
`ifdef SINGLE_STEP_EN
    input  step,
`endif
    input  run, ir, q,
    output ir_load, pc_load, jmux, rae, rbe, raa, rba, ie, ze, oe, we, wa,
           op, cal_value, halted, state
  );

  modport slave (
`ifdef SINGLE_STEP_EN
    output step,
`endif
    output run, ir, q,
    input  ir_load, pc_load, jmux, rae, rbe, raa, rba, ie, ze, oe, we, wa,
           op, cal_value, halted, state
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_fsm
// Multi-cycle control FSM for the 10-bit-instruction CPU. Sequences
// FETCH -> DECODE -> EXEC (EXEC_CYCLES) -> WRITE -> NEXT per instruction,
// 4 + EXEC_CYCLES cycles from FETCH to the PC-load cycle. IR == 0 is a
// sticky HALT that only reset leaves.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  cpu_ctrl_fsm_if.master (strobes, addresses, opcode, debug state)
// Optional feature macro: SINGLE_STEP_EN -- NEXT always returns to IDLE and
// a rising edge on step issues one instruction from IDLE (run still wins).
// ---------------------------------------------------------------------------
module cpu_ctrl_fsm #(
  parameter int INSTRUCTION_LEN = 10,
  parameter int EXEC_CYCLES     = 2
) (
  input  logic           clk,
  input  logic           rst,
  cpu_ctrl_fsm_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WRITE  = 3'd4,
    NEXT   = 3'd5,
    HALT   = 3'd6
  } state_t;

  // Everything the decoder produces; captured once at the end of DECODE.
  typedef struct packed {
    logic       rae;
    logic       rbe;
    logic       ie;
    logic       we;
    logic       ze;
    logic       oe;
    logic [1:0] raa;
    logic [1:0] rba;
    logic [1:0] wa;
    logic [2:0] op;
    logic [3:0] cal_value;
    logic       jmux;
    logic       jz;
    logic       jnz;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{jmux: 1'b1, default: '0};
  localparam logic [2:0] EXEC_LAST = 3'(EXEC_CYCLES - 1);

  state_t     state, state_next;
  ctrl_t      dec, ctrl;
  logic [2:0] exec_cnt;
  logic       jmux_write;
  logic       step_start;

  // Instruction decode (combinational, valid while IR is stable).
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    dec           = CTRL_RESET;
    dec.op        = bus.ir[8:6];
    dec.cal_value = bus.ir[3:0];
    if (bus.ir[9]) begin                       // LDI
      dec.wa = bus.ir[8:7]; dec.ie = 1'b1; dec.we = 1'b1;
    end else if (bus.ir[8]) begin              // ALU-reg
      dec.rae = 1'b1; dec.raa = bus.ir[3:2];
      dec.rbe = 1'b1; dec.rba = bus.ir[1:0];
      dec.wa  = bus.ir[5:4]; dec.we = 1'b1; dec.ze = 1'b1;
    end else if (bus.ir[7]) begin              // ALU-imm
      dec.rae = 1'b1; dec.raa = bus.ir[5:4];
      dec.wa  = bus.ir[5:4]; dec.we = 1'b1; dec.ze = 1'b1;
    end else begin
      case (bus.ir[6:4])
        3'b001: begin                          // MOV
          dec.rae = 1'b1; dec.raa = bus.ir[1:0];
          dec.wa  = bus.ir[3:2]; dec.we = 1'b1;
        end
        3'b010: begin
          if (bus.ir[3:2] == 2'b00) begin      // IN
            dec.wa = bus.ir[1:0]; dec.ie = 1'b1; dec.we = 1'b1;
          end else if (bus.ir[3:2] == 2'b01) begin // OUT
            dec.rae = 1'b1; dec.raa = bus.ir[1:0]; dec.oe = 1'b1;
          end
        end
        3'b011: begin                          // UNARY
          dec.rae = 1'b1; dec.raa = bus.ir[1:0];
          dec.wa  = bus.ir[3:2]; dec.we = 1'b1; dec.ze = 1'b1;
        end
        3'b100: dec.jmux = 1'b0;               // JMP
        3'b101: begin dec.jmux = bus.q;  dec.jz  = 1'b1; end // JZ
        3'b110: begin dec.jmux = ~bus.q; dec.jnz = 1'b1; end // JNZ
        3'b111: begin                          // CMP
          dec.rae = 1'b1; dec.raa = bus.ir[3:2];
          dec.rbe = 1'b1; dec.rba = bus.ir[1:0]; dec.ze = 1'b1;
        end
        default: ;                             // NOP
      endcase
    end
  end

  // Conditional branches look at Q again in WRITE, since an earlier ZE may
  // have changed it after DECODE.
  always_comb begin
    jmux_write = ctrl.jmux;
    if (ctrl.jz)       jmux_write = bus.q;
    else if (ctrl.jnz) jmux_write = ~bus.q;
  end

`ifdef SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_q <= 1'b0;
    else     step_q <= bus.step;
  end

  assign step_start = bus.step & ~step_q;
`else
  assign step_start = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      exec_cnt <= '0;
      ctrl     <= CTRL_RESET;
    end else begin
      state    <= state_next;
      exec_cnt <= (state == EXEC) ? exec_cnt + 3'd1 : 3'd0;
      if (state == DECODE)     ctrl      <= dec;
      else if (state == WRITE) ctrl.jmux <= jmux_write;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_next    = state;
    bus.ir_load   = 1'b0;
    bus.pc_load   = 1'b0;
    bus.rae       = 1'b0;
    bus.rbe       = 1'b0;
    bus.ie        = 1'b0;
    bus.we        = 1'b0;
    bus.ze        = 1'b0;
    bus.oe        = 1'b0;
    bus.halted    = 1'b0;
    bus.raa       = ctrl.raa;
    bus.rba       = ctrl.rba;
    bus.wa        = ctrl.wa;
    bus.op        = ctrl.op;
    bus.cal_value = ctrl.cal_value;
    bus.jmux      = ctrl.jmux;
    case (state)
      IDLE: if (bus.run || step_start) state_next = FETCH;
      FETCH: begin
        bus.ir_load = 1'b1;
        state_next  = DECODE;
      end
      DECODE: begin
        // Show the decode live so the read ports are set up during DECODE.
        bus.rae       = dec.rae;
        bus.rbe       = dec.rbe;
        bus.ie        = dec.ie;
        bus.raa       = dec.raa;
        bus.rba       = dec.rba;
        bus.wa        = dec.wa;
        bus.op        = dec.op;
        bus.cal_value = dec.cal_value;
        bus.jmux      = dec.jmux;
        state_next    = (bus.ir == '0) ? HALT : EXEC;
      end
      EXEC: begin
        bus.rae = ctrl.rae;
        bus.rbe = ctrl.rbe;
        bus.ie  = ctrl.ie;
        if (exec_cnt == EXEC_LAST) state_next = WRITE;
      end
      WRITE: begin
        bus.rae    = ctrl.rae;
        bus.rbe    = ctrl.rbe;
        bus.ie     = ctrl.ie;
        bus.we     = ctrl.we;
        bus.ze     = ctrl.ze;
        bus.oe     = ctrl.oe;
        bus.jmux   = jmux_write;
        state_next = NEXT;
      end
      NEXT: begin
        bus.pc_load = 1'b1;
`ifdef SINGLE_STEP_EN
        state_next  = IDLE;
`else
        state_next  = bus.run ? FETCH : IDLE;
`endif
      end
      HALT:    bus.halted = 1'b1;
      default: state_next = IDLE;
    endcase
  end

  assign bus.state = state;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_cpu_ctrl_fsm
// Directed self-checking bench for cpu_ctrl_fsm with EXEC_CYCLES = 2.
// Inputs are driven 1 time unit after the falling edge and outputs are
// checked at the same point, well away from the rising edge. Strobe
// monitors count pulses on every falling edge.
// ---------------------------------------------------------------------------
module tb_cpu_ctrl_fsm;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3,
                 S_WRITE = 4, S_NEXT = 5, S_HALT = 6;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_fails  = 0;
  int cnt_ir_load = 0, cnt_pc_load = 0, cnt_we = 0, cnt_ze = 0, cnt_oe = 0;
  int base_ir, base_pc, base_we, base_ze, base_oe;

  cpu_ctrl_fsm_if #(.INSTRUCTION_LEN(10)) bus ();

  cpu_ctrl_fsm #(
    .INSTRUCTION_LEN(10),
    .EXEC_CYCLES    (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ir_load) cnt_ir_load++;
    if (bus.pc_load) cnt_pc_load++;
    if (bus.we)      cnt_we++;
    if (bus.ze)      cnt_ze++;
    if (bus.oe)      cnt_oe++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required end before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic snap();
    base_ir = cnt_ir_load;
    base_pc = cnt_pc_load;
    base_we = cnt_we;
    base_ze = cnt_ze;
    base_oe = cnt_oe;
  endtask

  initial begin
    rst    = 1'b1;
    bus.run = 1'b0;
    bus.ir  = '0;
    bus.q   = 1'b0;
`ifdef SINGLE_STEP_EN
    bus.step = 1'b0;
`endif
    tick(3);

    // Reset state
    check("rst_state",   32'(bus.state),  S_IDLE);
    check("rst_jmux",    32'(bus.jmux),   1);
    check("rst_halted",  32'(bus.halted), 0);
    check("rst_strobes", 32'({bus.ir_load, bus.pc_load, bus.we, bus.oe, bus.ze}), 0);
    check("rst_addr",    32'({bus.raa, bus.rba, bus.wa, bus.op, bus.cal_value}), 0);
    rst = 1'b0;
    tick(2);
    check("idle_hold", 32'(bus.state), S_IDLE);

    // LDI r1,5 : FETCH c1, WRITE c5, NEXT c6, FETCH again c7
    snap();
    bus.ir  = 10'b10_1000_0101;
    bus.run = 1'b1;
    tick();
    check("ldi_fetch",   32'({bus.state, bus.ir_load}), {3'(S_FETCH), 1'b1});
    tick();
    check("ldi_decode",  32'({bus.state, bus.ie, bus.wa}), {3'(S_DECODE), 1'b1, 2'b01});
    tick(2);
    check("ldi_exec2",   32'({bus.state, bus.we}), {3'(S_EXEC), 1'b0});
    tick();
    check("ldi_write",   32'({bus.state, bus.we, bus.wa, bus.ie, bus.ze, bus.oe}),
                         {3'(S_WRITE), 1'b1, 2'b01, 1'b1, 1'b0, 1'b0});
    check("ldi_operand", 32'({bus.op, bus.cal_value}), {3'b010, 4'b0101});
    tick();
    check("ldi_next",    32'({bus.state, bus.pc_load, bus.we, bus.ie, bus.jmux}),
                         {3'(S_NEXT), 1'b1, 1'b0, 1'b0, 1'b1});
    tick();
`ifdef SINGLE_STEP_EN
    check("ldi_step_idle", 32'(bus.state), S_IDLE);
    tick();
`endif
    check("ldi_refetch", 32'(bus.state), S_FETCH);
    // Run drops mid-instruction: the instruction still completes
    bus.run = 1'b0;
    tick(5);
    check("ldi2_next", 32'({bus.state, bus.pc_load}), {3'(S_NEXT), 1'b1});
    tick();
    check("ldi2_park", 32'(bus.state), S_IDLE);
    check("ldi_counts", 32'({8'(cnt_ir_load - base_ir), 8'(cnt_pc_load - base_pc),
                             8'(cnt_we - base_we)}), {8'd2, 8'd2, 8'd2});

    // ALU-reg: OP=101 WA=10 RAA=10 RBA=01
    snap();
    bus.ir  = 10'b01_0110_1001;
    bus.run = 1'b1;
    tick(3);
    bus.run = 1'b0;
    check("alu_exec", 32'({bus.state, bus.rae, bus.rbe, bus.raa, bus.rba, bus.wa, bus.op}),
                      {3'(S_EXEC), 1'b1, 1'b1, 2'b10, 2'b01, 2'b10, 3'b101});
    tick(2);
    check("alu_write", 32'({bus.state, bus.we, bus.ze, bus.oe, bus.ie}),
                       {3'(S_WRITE), 1'b1, 1'b1, 1'b0, 1'b0});
    tick();
    check("alu_next",  32'({bus.we, bus.ze, bus.rae, bus.rbe}), 0);
    tick();
    check("alu_pulses", 32'({8'(cnt_we - base_we), 8'(cnt_ze - base_ze)}), {8'd1, 8'd1});

    // OUT r3: OE only, no WE
    snap();
    bus.ir  = 10'b00_0010_0111;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    check("out_decode", 32'({bus.rae, bus.raa, bus.ie}), {1'b1, 2'b11, 1'b0});
    tick(3);
    check("out_write", 32'({bus.state, bus.oe, bus.we, bus.ze}), {3'(S_WRITE), 1'b1, 1'b0, 1'b0});
    tick(2);
    check("out_pulses", 32'({8'(cnt_oe - base_oe), 8'(cnt_we - base_we)}), {8'd1, 8'd0});

    // JZ, Q rises between DECODE and WRITE -> PC+1
    bus.ir  = 10'b00_0101_0000;
    bus.q   = 1'b0;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    check("jz1_decode", 32'(bus.jmux), 0);
    tick();
    bus.q = 1'b1;
    tick(2);
    check("jz1_write", 32'(bus.jmux), 1);
    tick();
    check("jz1_next", 32'({bus.pc_load, bus.jmux}), {1'b1, 1'b1});
    tick();

    // JZ, Q falls before WRITE -> branch
    bus.q   = 1'b1;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    check("jz0_decode", 32'(bus.jmux), 1);
    tick();
    bus.q = 1'b0;
    tick(3);
    check("jz0_next", 32'({bus.state, bus.pc_load, bus.jmux}), {3'(S_NEXT), 1'b1, 1'b0});
    tick();

    // Reset mid-EXEC of ALU-reg with Run held high
    bus.ir  = 10'b01_0110_1001;
    bus.run = 1'b1;
    tick(3);
    check("abort_in_exec", 32'(bus.state), S_EXEC);
    snap();
    rst = 1'b1;
    #1;
    check("abort_state", 32'({bus.state, bus.jmux, bus.rae, bus.rbe}), {3'(S_IDLE), 1'b1, 1'b0, 1'b0});
    tick(2);
    bus.run = 1'b0;
    rst = 1'b0;
    tick(6);
    check("abort_quiet", 32'({8'(cnt_we - base_we), 8'(cnt_oe - base_oe),
                              8'(cnt_pc_load - base_pc)}), 0);
    check("abort_jmux", 32'({bus.state, bus.jmux}), {3'(S_IDLE), 1'b1});

    // HALT on IR == 0, sticky against Run toggling
    bus.ir  = '0;
    bus.run = 1'b1;
    tick(2);
    check("halt_decode", 32'({bus.state, bus.rae, bus.ie, bus.we}), {3'(S_DECODE), 3'b000});
    tick();
    check("halt_enter", 32'({bus.state, bus.halted}), {3'(S_HALT), 1'b1});
    snap();
    for (int i = 0; i < 20; i++) begin
      bus.run = ~bus.run;
      tick();
    end
    check("halt_sticky", 32'({bus.state, bus.halted}), {3'(S_HALT), 1'b1});
    check("halt_quiet",  32'({8'(cnt_ir_load - base_ir), 8'(cnt_pc_load - base_pc)}), 0);
    bus.run = 1'b0;
    rst = 1'b1;
    #1;
    check("halt_exit", 32'({bus.state, bus.halted}), {3'(S_IDLE), 1'b0});
    tick();
    rst = 1'b0;
    tick();

`ifdef SINGLE_STEP_EN
    // Single step with Run low
    snap();
    bus.ir = 10'b10_1000_0101;
    tick(5);
    check("step_none", 32'({bus.state, 8'(cnt_ir_load - base_ir)}), {3'(S_IDLE), 8'd0});
    bus.step = 1'b1;
    tick();
    check("step_fetch", 32'(bus.state), S_FETCH);
    tick(6);
    check("step_park", 32'(bus.state), S_IDLE);
    tick(4);
    check("step_once", 32'({bus.state, 8'(cnt_ir_load - base_ir), 8'(cnt_pc_load - base_pc)}),
                       {3'(S_IDLE), 8'd1, 8'd1});
    bus.step = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
